mux_n_rr: RTL

MUX_N_RR -- requirements
Module: mux_n_rr

---
 rtl/mux_n_rr.sv | 67 ++++++
 1 files changed

// File: rtl/mux_n_rr.sv
// rtl/mux_n_rr.sv - N-channel arbitrated mux (round-robin or fixed priority) with one output register stage
module mux_n_rr #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int FIXED = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_sel
);

    localparam int SELW = $clog2(N);

    logic [SELW-1:0] ptr;
    logic [N-1:0]    grant;
    logic [SELW-1:0] gsel;
    logic            any_valid;
    logic            load_en;

    // The register stage can accept a word when empty or draining this cycle; never while in reset.
    assign load_en  = rst_n & (~out_valid | out_ready);
    assign in_ready = grant & {N{load_en}};

    // Search starts at ptr (or 0 in fixed mode) and wraps modulo N, so indexes stay below N.
    always_comb begin
        logic [SELW-1:0] idx;
        grant     = '0;
        gsel      = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = (FIXED != 0) ? SELW'(i) : SELW'((int'(ptr) + i) % N);
            if (!any_valid && in_valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                gsel       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gsel)*WIDTH +: WIDTH];
                out_sel   <= gsel;
                if (FIXED == 0) begin
                    ptr <= SELW'((int'(gsel) + 1) % N);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
